// File: rtl/xlr_vec_engine.sv
// Multi-bank line engine: COPY, SUM and FILL over accelerator memory banks,
// commanded through the host register block and reporting with a done pulse.
module xlr_vec_engine #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int NUM_WORDS          = 8,
  parameter int NUM_GPP            = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  output logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
  output logic [NUM_MEMS*32*NUM_WORDS-1:0]         xlr_mem_wdata,
  output logic [NUM_MEMS*4*NUM_WORDS-1:0]          xlr_mem_be,
  output logic [NUM_MEMS-1:0]                      xlr_mem_rd,
  output logic [NUM_MEMS-1:0]                      xlr_mem_wr,
  input  logic [NUM_MEMS*32*NUM_WORDS-1:0]         xlr_mem_rdata,
  input  logic [NUM_GPP*32-1:0]                    host_regs,
  input  logic                                     host_regs_valid_pulse,
  output logic [NUM_GPP*32-1:0]                    host_regs_data_out,
  output logic                                     host_regs_valid_out
);
  localparam int LW = 32 * NUM_WORDS;
  localparam int AW = LOG2_LINES_PER_MEM;
  localparam int SW = 40;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_COPY = 2'd0;
  localparam logic [1:0] OP_SUM  = 2'd1;
  localparam logic [1:0] OP_FILL = 2'd2;

  logic [2:0]              r_state;
  logic [1:0]              r_op;
  logic [3:0]              r_src;
  logic [3:0]              r_dst;
  logic [AW-1:0]           r_addr;
  logic [AW:0]             r_idx;
  logic [AW:0]             r_len;
  logic [LW-1:0]           r_line;
  logic [31:0]             r_acc;
  logic                    r_ovf;
  logic                    r_busy;
  logic [NUM_GPP*32-1:0]   r_data_out;

  logic [1:0]              w_op;
  logic [3:0]              w_src;
  logic [3:0]              w_dst;
  logic [31:0]             w_start;
  logic [31:0]             w_len;
  logic [31:0]             w_pat;
  logic [33:0]             w_end;
  logic                    w_err;
  logic [LW-1:0]           w_rdata_sel;
  logic [SW-1:0]           w_line_sum;
  logic [SW-1:0]           w_acc_wide;
  logic                    w_carry;
  logic                    w_last;
  logic                    w_busy_next;
  logic                    w_ovf_fin;
  logic [31:0]             w_acc_fin;
  logic [NUM_GPP*32-1:0]   w_done_out;
  logic                    w_unused;

  assign w_op    = host_regs[1:0];
  assign w_src   = host_regs[35:32];
  assign w_dst   = host_regs[39:36];
  assign w_start = host_regs[95:64];
  assign w_len   = host_regs[127:96];
  assign w_pat   = host_regs[159:128];
  assign w_unused = ^host_regs;

  // Range check done in 34 bits so a huge start/length cannot wrap past the limit.
  assign w_end = {2'b00, w_start} + {2'b00, w_len};
  assign w_err = (w_op == 2'd3) || (w_len == 32'd0) ||
                 (32'(w_src) >= 32'(NUM_MEMS)) || (32'(w_dst) >= 32'(NUM_MEMS)) ||
                 (w_end > (34'd1 << AW));

  always_comb begin
    w_rdata_sel = '0;
    for (int i = 0; i < NUM_MEMS; i++) begin
      if (r_src == 4'(i)) w_rdata_sel = xlr_mem_rdata[i*LW +: LW];
    end
  end

  always_comb begin
    w_line_sum = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w_line_sum = w_line_sum + {{(SW-32){1'b0}}, w_rdata_sel[i*32 +: 32]};
    end
  end

  assign w_acc_wide  = {{(SW-32){1'b0}}, r_acc} + w_line_sum;
  assign w_carry     = |w_acc_wide[SW-1:32];
  assign w_last      = (r_idx == r_len - 1'b1);
  assign w_busy_next = r_busy | (host_regs_valid_pulse & (r_state != S_IDLE));
  assign w_ovf_fin   = r_ovf | ((r_state == S_CAP) && (r_op == OP_SUM) && w_carry);
  assign w_acc_fin   = (r_state == S_CAP) ? w_acc_wide[31:0] : r_acc;

  // Result words for a successful command, sampled on the transition into DONE.
  always_comb begin
    w_done_out        = '0;
    w_done_out[1:0]   = 2'd1;
    w_done_out[8]     = w_ovf_fin;
    w_done_out[9]     = w_busy_next;
    w_done_out[63:32] = (r_op == OP_SUM) ? w_acc_fin : 32'd0;
    w_done_out[95:64] = 32'(r_idx) + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_addr     <= '0;
      r_idx      <= '0;
      r_len      <= '0;
      r_line     <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_busy <= w_busy_next;
      case (r_state)
        S_IDLE: begin
          if (host_regs_valid_pulse) begin
            r_op   <= w_op;
            r_src  <= w_src;
            r_dst  <= w_dst;
            r_addr <= w_start[AW-1:0];
            r_len  <= w_len[AW:0];
            r_idx  <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
            r_line <= {NUM_WORDS{w_pat}};
            if (w_err) begin
              r_data_out <= {{(NUM_GPP*32-2){1'b0}}, 2'd2};
              r_state    <= S_DONE;
            end else begin
              r_state <= (w_op == OP_FILL) ? S_WR : S_RD;
            end
          end
        end
        S_RD: r_state <= S_CAP;
        S_CAP: begin
          r_line <= w_rdata_sel;
          if (r_op == OP_SUM) begin
            r_acc <= w_acc_wide[31:0];
            r_ovf <= r_ovf | w_carry;
            if (w_last) begin
              r_data_out <= w_done_out;
              r_state    <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_addr  <= r_addr + 1'b1;
              r_state <= S_RD;
            end
          end else begin
            r_state <= S_WR;
          end
        end
        S_WR: begin
          if (w_last) begin
            r_data_out <= w_done_out;
            r_state    <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_state <= (r_op == OP_FILL) ? S_WR : S_RD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host_regs_valid_out = (r_state == S_DONE);
  assign host_regs_data_out  = r_data_out;

  // Strobes decode straight from registered state so reset drops them at once.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MEMS; gi++) begin : g_bank
      logic w_rd_sel;
      logic w_wr_sel;
      assign w_rd_sel = (r_state == S_RD) && (r_src == 4'(gi));
      assign w_wr_sel = (r_state == S_WR) && (r_dst == 4'(gi));
      assign xlr_mem_rd[gi] = w_rd_sel;
      assign xlr_mem_wr[gi] = w_wr_sel;
      assign xlr_mem_addr[gi*AW +: AW]        = (w_rd_sel || w_wr_sel) ? r_addr : '0;
      assign xlr_mem_wdata[gi*LW +: LW]       = w_wr_sel ? r_line : '0;
      assign xlr_mem_be[gi*(LW/8) +: (LW/8)]  = w_wr_sel ? '1 : '0;
    end
  endgenerate
endmodule

// File: tb/tb_xlr_vec_engine.sv
// Randomized bench for xlr_vec_engine: bank memory model, line-level reference
// model and strobe monitor.
module tb_xlr_vec_engine;
  localparam int NM    = 2;
  localparam int AW    = 8;
  localparam int NW    = 8;
  localparam int NG    = 16;
  localparam int LW    = 32 * NW;
  localparam int LINES = 1 << AW;

  typedef struct packed {
    logic          w;
    logic [3:0]    bank;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic [LW/8-1:0] be;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM*AW-1:0]    addr;
  logic [NM*LW-1:0]    wdata;
  logic [NM*LW/8-1:0]  be;
  logic [NM-1:0]       rd;
  logic [NM-1:0]       wr;
  logic [NM*LW-1:0]    rdata = '0;
  logic [NG*32-1:0]    host_regs = '0;
  logic                pulse = 1'b0;
  logic [NG*32-1:0]    dout;
  logic                vout;

  xlr_vec_engine #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW), .NUM_WORDS(NW), .NUM_GPP(NG)) dut (
    .clk(clk), .rst_n(rst_n),
    .xlr_mem_addr(addr), .xlr_mem_wdata(wdata), .xlr_mem_be(be),
    .xlr_mem_rd(rd), .xlr_mem_wr(wr), .xlr_mem_rdata(rdata),
    .host_regs(host_regs), .host_regs_valid_pulse(pulse),
    .host_regs_data_out(dout), .host_regs_valid_out(vout)
  );

  logic [LW-1:0] mem [NM][LINES];
  logic [LW-1:0] ref_mem [NM][LINES];
  logic          pl_en = 1'b0;
  int            pl_bank = 0;
  int            pl_line = 0;
  logic [LW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_bank][pl_line] <= pl_data;
    for (int b = 0; b < NM; b++) begin
      if (rd[b]) rdata[b*LW +: LW] <= mem[b][addr[b*AW +: AW]];
      if (wr[b]) mem[b][addr[b*AW +: AW]] <= wdata[b*LW +: LW];
    end
  end

  ev_t evq[$];
  int  excl_err = 0;
  int  idle_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones({rd, wr}) > 1) excl_err++;
      for (int b = 0; b < NM; b++) begin
        if (rd[b]) evq.push_back('{1'b0, 4'(b), addr[b*AW +: AW], '0, '0});
        if (wr[b]) evq.push_back('{1'b1, 4'(b), addr[b*AW +: AW], wdata[b*LW +: LW], be[b*LW/8 +: LW/8]});
        if (!rd[b] && !wr[b] && ((addr[b*AW +: AW] != '0) || (wdata[b*LW +: LW] != '0) ||
                                 (be[b*LW/8 +: LW/8] != '0))) idle_err++;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int bank, input int line, input logic [LW-1:0] data);
    pl_en = 1'b1; pl_bank = bank; pl_line = line; pl_data = data;
    ref_mem[bank][line] = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  function automatic logic [LW-1:0] rep(input logic [31:0] pat);
    return {NW{pat}};
  endfunction

  // Reference: walk the command line by line in plain arithmetic.
  task automatic run_cmd(input int op, input int src, input int dst, input int start,
                         input int len, input logic [31:0] pat, input int busy_at, input string name);
    ev_t             exp_q[$];
    longint unsigned total = 0;
    bit              err;
    int              per, exp_k, k, base, ev_err, mem_err;
    bit              busy, ovf;
    logic [LW-1:0]   line;
    logic [31:0]     exp0, exp1, exp2;

    err = (op == 3) || (len == 0) || (src >= NM) || (dst >= NM) ||
          (longint'(start) + longint'(len) > longint'(LINES));
    per = (op == 0) ? 3 : (op == 1) ? 2 : 1;
    exp_k = err ? 0 : per * len;
    if (!err) begin
      for (int i = 0; i < len; i++) begin
        int a = start + i;
        if (op == 0) begin
          line = ref_mem[src][a];
          exp_q.push_back('{1'b0, 4'(src), AW'(a), '0, '0});
          exp_q.push_back('{1'b1, 4'(dst), AW'(a), line, '1});
          ref_mem[dst][a] = line;
        end else if (op == 1) begin
          line = ref_mem[src][a];
          exp_q.push_back('{1'b0, 4'(src), AW'(a), '0, '0});
          for (int w = 0; w < NW; w++) total += longint'(line[w*32 +: 32]);
        end else begin
          exp_q.push_back('{1'b1, 4'(dst), AW'(a), rep(pat), '1});
          ref_mem[dst][a] = rep(pat);
        end
      end
    end
    ovf  = (total >> 32) != 0;
    busy = (busy_at >= 0) && (busy_at < exp_k);
    exp0 = err ? 32'd2 : (32'd1 | (32'(ovf) << 8) | (32'(busy) << 9));
    exp1 = (!err && op == 1) ? total[31:0] : 32'd0;
    exp2 = err ? 32'd0 : 32'(len);

    base = evq.size();
    host_regs = '0;
    host_regs[0 +: 32]   = 32'(op);
    host_regs[32 +: 32]  = 32'((dst << 4) | src);
    host_regs[64 +: 32]  = 32'(start);
    host_regs[96 +: 32]  = 32'(len);
    host_regs[128 +: 32] = pat;
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    k = 0;
    while (!vout && k < 200) begin
      pulse = (k == busy_at);
      if (k == busy_at) for (int w = 0; w < NG; w++) host_regs[w*32 +: 32] = $urandom();
      @(negedge clk);
      k++;
    end
    pulse = 1'b0;

    check({name, "_latency"}, 64'(k), 64'(exp_k));
    check({name, "_out0"}, 64'(dout[0 +: 32]), 64'(exp0));
    check({name, "_out1"}, 64'(dout[32 +: 32]), 64'(exp1));
    check({name, "_out2"}, 64'(dout[64 +: 32]), 64'(exp2));
    check({name, "_out_rest"}, 64'(|dout[NG*32-1:96]), 64'd0);
    check({name, "_nev"}, 64'(evq.size() - base), 64'(exp_q.size()));
    ev_err = 0;
    foreach (exp_q[i]) begin
      if (base + i >= evq.size()) ev_err++;
      else if (evq[base+i].w != exp_q[i].w || evq[base+i].bank != exp_q[i].bank ||
               evq[base+i].addr != exp_q[i].addr ||
               (exp_q[i].w && (evq[base+i].data !== exp_q[i].data || evq[base+i].be !== exp_q[i].be)))
        ev_err++;
    end
    check({name, "_events"}, 64'(ev_err), 64'd0);
    check({name, "_excl"}, 64'(excl_err), 64'd0);
    check({name, "_idle_zero"}, 64'(idle_err), 64'd0);
    @(negedge clk);
    check({name, "_vout_1cyc"}, 64'(vout), 64'd0);
    mem_err = 0;
    for (int b = 0; b < NM; b++)
      for (int l = 0; l < LINES; l++)
        if (mem[b][l] !== ref_mem[b][l]) mem_err++;
    check({name, "_mem"}, 64'(mem_err), 64'd0);
    $display("[TB] %s op=%0d src=%0d dst=%0d start=0x%0h len=%0d -> out0=0x%0h out1=0x%0h out2=%0d cycles=%0d",
             name, op, src, dst, start, len, dout[0 +: 32], dout[32 +: 32], dout[64 +: 32], k);
  endtask

  initial begin
    int op, src, dst, len, start, bsy;
    logic [LW-1:0] line;

    repeat (2) @(negedge clk);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_vout", 64'(vout), 64'd0);
    check("rst_dout", 64'(|dout), 64'd0);
    check("rst_bus", 64'(|{addr, wdata, be}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int b = 0; b < NM; b++)
      for (int l = 0; l < LINES; l++) begin
        for (int w = 0; w < NW; w++) line[w*32 +: 32] = $urandom();
        preload(b, l, line);
      end
    for (int l = 0; l < 2; l++) begin
      for (int w = 0; w < NW; w++) line[w*32 +: 32] = 32'(l*NW + w + 1);
      preload(0, l, line);
    end

    run_cmd(2, 0, 1, 'h10, 4, 32'hA5A5A5A5, -1, "fill4");
    run_cmd(1, 0, 0, 0, 2, 32'h0, -1, "sum2");
    check("sum2_136", 64'(dout[32 +: 32]), 64'd136);
    run_cmd(0, 0, 1, 'hFE, 2, 32'h0, -1, "copy_top");
    run_cmd(0, 0, 1, 'hFE, 3, 32'h0, -1, "copy_oob");
    preload(0, 'h20, '1);
    run_cmd(1, 0, 1, 'h20, 1, 32'h0, -1, "sum_ovf");
    check("sum_ovf_val", 64'(dout[32 +: 32]), 64'hFFFFFFF8);
    run_cmd(0, 1, 0, 'h30, 3, 32'h0, 2, "copy_busy");
    run_cmd(2, 0, 0, 'h50, 2, 32'h12345678, -1, "busy_clr");
    run_cmd(3, 0, 1, 0, 1, 32'h0, -1, "err_op3");
    run_cmd(0, 0, 1, 4, 0, 32'h0, -1, "err_len0");
    run_cmd(1, 2, 0, 4, 1, 32'h0, -1, "err_src");
    run_cmd(2, 0, 5, 4, 1, 32'h0, -1, "err_dst");
    run_cmd(0, 1, 1, 'h60, 2, 32'h0, -1, "copy_same");

    for (int t = 0; t < 24; t++) begin
      op    = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      src   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, 1));
      dst   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, 1));
      len   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      start = ($urandom_range(0, 5) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 249));
      bsy   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cmd(op, src, dst, start, len, $urandom(), bsy, "rand");
    end

    host_regs = '0;
    host_regs[32 +: 32]  = 32'h10;
    host_regs[64 +: 32]  = 32'h40;
    host_regs[96 +: 32]  = 32'd4;
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    check("midrst_rd_active", 64'(rd), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("midrst_wr_active", 64'(wr), 64'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", 64'({rd, wr}), 64'd0);
    check("midrst_vout", 64'(vout), 64'd0);
    @(negedge clk);
    check("midrst_vout_hold", 64'(vout), 64'd0);
    check("midrst_dout", 64'(|dout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_vout", 64'(vout), 64'd0);
    run_cmd(2, 0, 1, 'h80, 3, 32'hC0FFEE00, -1, "fill_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
